rr_arbiter_16: RTL
==================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum WAIT-state cycles before abort; 0 disables the timeout.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  16  per-requester request, level; requester i holds req[i] until granted.
REQ-005 res_ready  input  1  shared resource accepts the issued grant this cycle.
REQ-006 res_done  input  1  shared resource finished the accepted transaction; one-cycle pulse.
REQ-007 gnt  output  16  one-hot grant, registered; all zero when no grant is held.
REQ-008 gnt_idx  output  4  binary index of the set bit in gnt, registered.
REQ-009 gnt_valid  output  1  grant offered to the resource (ISSUE state).
REQ-010 busy  output  1  resource owned by gnt_idx (WAIT state).
REQ-011 timeout  output  1  one-cycle pulse on WAIT abort.

Function
REQ-012 State machine has exactly three states: IDLE, ISSUE, WAIT.
REQ-013 A 4-bit priority pointer ptr selects the highest-priority requester.
REQ-014 IDLE, req != 0: select the first set bit of req searching circularly from ptr upward (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
REQ-015 IDLE, req != 0: load gnt/gnt_idx with the selection and enter ISSUE next cycle; latency is one cycle from req sampled to gnt_valid=1.
REQ-016 IDLE, req == 0: remain in IDLE with gnt=0.
REQ-017 ISSUE: gnt_valid=1; gnt and gnt_idx are held stable.
REQ-018 ISSUE with res_ready=1: enter WAIT and set ptr <= gnt_idx+1 mod 16 (15 wraps to 0).
REQ-019 ISSUE with req[gnt_idx]=0 and res_ready=0: withdrawal; return to IDLE, clear gnt, leave ptr unchanged.
REQ-020 ISSUE with req[gnt_idx]=0 and res_ready=1 in the same cycle: res_ready wins; enter WAIT.
REQ-021 WAIT: busy=1, gnt_valid=0; gnt and gnt_idx are held stable.
REQ-022 WAIT: an 8-bit cycle counter starts at 0 on entry and increments each WAIT cycle.
REQ-023 WAIT with res_done=1: enter IDLE and clear gnt/gnt_idx.
REQ-024 WAIT, counter == TIMEOUT_CYC-1, res_done=0, TIMEOUT_CYC != 0: pulse timeout for one cycle, enter IDLE, clear gnt.
REQ-025 res_done on the timeout cycle: res_done wins; no timeout pulse.
REQ-026 res_done in IDLE or ISSUE is ignored.
REQ-027 res_ready in IDLE or WAIT is ignored.
REQ-028 Requests change only on grant; new requests arriving during ISSUE/WAIT are arbitrated on the next IDLE.
REQ-029 Back-to-back: minimum spacing is done -> IDLE (1 cycle) -> ISSUE; gnt_valid reasserts 2 cycles after res_done.
REQ-030 Invariants: gnt has at most one bit set; gnt_idx == encode(gnt) whenever gnt != 0; gnt_valid and busy are never both 1.

Reset
REQ-031 With reset=1 at a clock edge: state=IDLE, ptr=0, counter=0, gnt=0, gnt_idx=0, gnt_valid=0, busy=0, timeout=0.
REQ-032 Reset asserted in ISSUE or WAIT abandons the transaction; no timeout pulse and no ptr update.
REQ-033 The first arbitration after reset deasserts uses ptr=0.

Verification
REQ-034 Priority, wrap and pointer advance: after reset, req=16'h8001 -> gnt=16'h0001, gnt_idx=0.
  - Then res_ready, res_done, req=16'h8001 again -> gnt=16'h8000, gnt_idx=15.
  - After accept, ptr=0.
REQ-035 Fairness: req=16'hFFFF held with res_ready=1 and res_done one cycle after accept -> gnt_idx sequence 0,1,...,15,0.
  - Each requester is granted once per 16 grants.
REQ-036 Withdrawal: grant idx 5 in ISSUE, drop req[5] with res_ready=0 -> IDLE next cycle, gnt=0.
  - With req=16'h0060 afterwards, the next gnt_idx=5 again (ptr unchanged).
REQ-037 Timeout: TIMEOUT_CYC=4, accept with no res_done -> timeout=1 on the 4th WAIT cycle, then IDLE.
  - Same setup with res_done on the 4th WAIT cycle -> timeout stays 0.
REQ-038 Reset mid-WAIT: reset in WAIT with gnt_idx=9 -> next cycle all outputs 0.
  - With req=16'h0200 afterwards, gnt_idx=9 is granted from ptr=0.
REQ-039 Continuous checks across all tests: assertions on REQ-030, and no grant to a requester whose req was 0 at arbitration.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a registered one-hot grant, an
// issue/accept handshake to a shared resource, and an optional WAIT-state timeout.
module rr_arbiter_16 #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        res_ready,
  input  logic        res_done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Terminal count; when TIMEOUT_CYC is 0 the value is unused (TO_EN masks it).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam bit         TO_EN    = (TIMEOUT_CYC != 0);

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] gnt_reg, gnt_next;
  logic [3:0]  idx_reg, idx_next;

  logic [15:0] rot;
  logic [3:0]  sel_off;
  logic [3:0]  sel_idx;
  logic        timeout_hit;

  // rot[k] is the request k positions above the pointer, wrapping mod 16.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rot
      assign rot[gi] = req[ptr_reg + 4'(gi)];
    end
  endgenerate

  always_comb begin
    sel_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) sel_off = 4'(i);
    end
  end

  assign sel_idx = ptr_reg + sel_off;

  // res_done on the terminal cycle wins over the abort; reset suppresses it too.
  assign timeout_hit = TO_EN && (state_reg == WAIT) && (cnt_reg == CNT_LAST)
                       && !res_done && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 4'd0;
      cnt_reg   <= 8'd0;
      gnt_reg   <= 16'd0;
      idx_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = 16'd0;
        idx_next = 4'd0;
        if (|req) begin
          state_next = ISSUE;
          gnt_next   = 16'd1 << sel_idx;
          idx_next   = sel_idx;
        end
      end
      ISSUE: begin
        if (res_ready) begin
          state_next = WAIT;
          ptr_next   = idx_reg + 4'd1;
          cnt_next   = 8'd0;
        end else if (!req[idx_reg]) begin
          state_next = IDLE;
          gnt_next   = 16'd0;
          idx_next   = 4'd0;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (res_done || timeout_hit) begin
          state_next = IDLE;
          gnt_next   = 16'd0;
          idx_next   = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 16'd0;
        idx_next   = 4'd0;
      end
    endcase
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = (state_reg == ISSUE);
  assign busy      = (state_reg == WAIT);
  assign timeout   = timeout_hit;

endmodule
